// File: rtl/simd_reg_file.sv
// simd_reg_file: unified scalar/vector operand register file with per-lane write
// masking, optional write-to-read bypass, hardwired-zero scalar 0 and a
// reservation scoreboard that flags RAW hazards against long-latency writebacks.
module simd_reg_file #(
  parameter int unsigned regSize        = 16,
  parameter int unsigned vecRegQuantity = 8,
  parameter int unsigned scRegQuantity  = 16,
  parameter int unsigned selBits        = 5,
  parameter int unsigned vectorSize     = 4,
  parameter bit          BYPASS         = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [selBits-1:0]            i_rsel1,
  input  logic [selBits-1:0]            i_rsel2,
  input  logic                          i_wr_en,
  input  logic [selBits-1:0]            i_wr_addr,
  input  logic [vectorSize-1:0]         i_wr_lane_mask,
  input  logic [vectorSize*regSize-1:0] i_data_in,
  input  logic                          i_rsv_en,
  input  logic [selBits-1:0]            i_rsv_addr,
  output logic [vectorSize*regSize-1:0] o_operand1,
  output logic [vectorSize*regSize-1:0] o_operand2,
  output logic                          o_hazard1,
  output logic                          o_hazard2,
  output logic [selBits:0]              o_pending_count
);

  localparam int unsigned IdxBits = selBits - 1;
  localparam int unsigned VecIdxW = (vecRegQuantity > 1) ? $clog2(vecRegQuantity) : 1;
  localparam int unsigned ScIdxW  = (scRegQuantity > 1) ? $clog2(scRegQuantity) : 1;
  localparam int unsigned DataW   = vectorSize * regSize;
  localparam int unsigned CntW    = selBits + 1;

  logic [regSize-1:0]        r_vec [vecRegQuantity][vectorSize];
  logic [regSize-1:0]        r_sc  [scRegQuantity];
  logic [vecRegQuantity-1:0] r_vec_busy;
  logic [scRegQuantity-1:0]  r_sc_busy;
  logic [CntW-1:0]           w_pending;

  // Scalar index 0 is hardwired to zero, so it never counts as a real target.
  function automatic logic sc_valid(input logic [selBits-1:0] a);
    return a[selBits-1] && (a[IdxBits-1:0] != '0) && (32'(a[IdxBits-1:0]) < scRegQuantity);
  endfunction

  function automatic logic vec_valid(input logic [selBits-1:0] a);
    return !a[selBits-1] && (32'(a[IdxBits-1:0]) < vecRegQuantity);
  endfunction

  function automatic logic fwd_hit(input logic [selBits-1:0] a);
    return BYPASS && i_wr_en && (i_wr_addr == a);
  endfunction

  // Read path: scalars broadcast, vectors per lane; forwarding merges masked lanes.
  function automatic logic [DataW-1:0] read_op(input logic [selBits-1:0] a);
    logic [DataW-1:0] res;
    logic             fwd;
    res = '0;
    fwd = fwd_hit(a);
    if (sc_valid(a)) begin
      for (int i = 0; i < vectorSize; i++) begin
        res[i*regSize +: regSize] = fwd ? i_data_in[regSize-1:0] : r_sc[a[ScIdxW-1:0]];
      end
    end else if (vec_valid(a)) begin
      for (int i = 0; i < vectorSize; i++) begin
        res[i*regSize +: regSize] = (fwd && i_wr_lane_mask[i]) ? i_data_in[i*regSize +: regSize]
                                                               : r_vec[a[VecIdxW-1:0]][i];
      end
    end
    return res;
  endfunction

  function automatic logic busy_of(input logic [selBits-1:0] a);
    if (sc_valid(a)) return r_sc_busy[a[ScIdxW-1:0]];
    if (vec_valid(a)) return r_vec_busy[a[VecIdxW-1:0]];
    return 1'b0;
  endfunction

  // Combinational read ports and hazard flags.
  always_comb begin
    o_operand1 = read_op(i_rsel1);
    o_operand2 = read_op(i_rsel2);
    o_hazard1  = busy_of(i_rsel1) & ~fwd_hit(i_rsel1);
    o_hazard2  = busy_of(i_rsel2) & ~fwd_hit(i_rsel2);
  end

  // Popcount of all busy bits.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < vecRegQuantity; i++) w_pending = w_pending + CntW'(r_vec_busy[i]);
    for (int i = 0; i < scRegQuantity; i++) w_pending = w_pending + CntW'(r_sc_busy[i]);
  end

  assign o_pending_count = w_pending;

  // Register writes and scoreboard updates; reservation is assigned last so it wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int v = 0; v < vecRegQuantity; v++) begin
        for (int l = 0; l < vectorSize; l++) r_vec[v][l] <= '0;
      end
      for (int s = 0; s < scRegQuantity; s++) r_sc[s] <= '0;
      r_vec_busy <= '0;
      r_sc_busy  <= '0;
    end else begin
      if (i_wr_en && sc_valid(i_wr_addr)) begin
        r_sc[i_wr_addr[ScIdxW-1:0]]      <= i_data_in[regSize-1:0];
        r_sc_busy[i_wr_addr[ScIdxW-1:0]] <= 1'b0;
      end
      if (i_wr_en && vec_valid(i_wr_addr)) begin
        for (int l = 0; l < vectorSize; l++) begin
          if (i_wr_lane_mask[l]) r_vec[i_wr_addr[VecIdxW-1:0]][l] <= i_data_in[l*regSize +: regSize];
        end
        r_vec_busy[i_wr_addr[VecIdxW-1:0]] <= 1'b0;
      end
      if (i_rsv_en && sc_valid(i_rsv_addr)) r_sc_busy[i_rsv_addr[ScIdxW-1:0]] <= 1'b1;
      if (i_rsv_en && vec_valid(i_rsv_addr)) r_vec_busy[i_rsv_addr[VecIdxW-1:0]] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_reg_file.sv
// Scoreboard bench for simd_reg_file: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against the DUT (and a no-bypass twin).
module tb_simd_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsel1, rsel2, wr_addr, rsv_addr;
  logic        wr_en, rsv_en;
  logic [3:0]  wr_mask;
  logic [63:0] data_in;
  logic [63:0] op1, op2, nb_op1, nb_op2;
  logic        hz1, hz2, nb_hz1, nb_hz2;
  logic [5:0]  cnt, nb_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        hz1;
    logic        hz2;
    logic [5:0]  cnt;
    bit          chk_nb;
    logic [63:0] nb_op1;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  simd_reg_file #(.BYPASS(1'b1)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_rsel1(rsel1), .i_rsel2(rsel2),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_lane_mask(wr_mask), .i_data_in(data_in),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_operand1(op1), .o_operand2(op2), .o_hazard1(hz1), .o_hazard2(hz2),
    .o_pending_count(cnt)
  );

  simd_reg_file #(.BYPASS(1'b0)) u_nb (
    .i_clk(clk), .i_reset(reset), .i_rsel1(rsel1), .i_rsel2(rsel2),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_lane_mask(wr_mask), .i_data_in(data_in),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .o_operand1(nb_op1), .o_operand2(nb_op2), .o_hazard1(nb_hz1), .o_hazard2(nb_hz2),
    .o_pending_count(nb_cnt)
  );

  function automatic logic [63:0] v(input logic [15:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] bc(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  task automatic cyc(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                     input logic we, input logic [4:0] wa, input logic [3:0] m,
                     input logic [63:0] d, input logic rv, input logic [4:0] ra);
    @(posedge clk);
    #1;
    reset = rst; rsel1 = r1; rsel2 = r2;
    wr_en = we; wr_addr = wa; wr_mask = m; data_in = d;
    rsv_en = rv; rsv_addr = ra;
  endtask

  task automatic exp_push(input string n, input logic [63:0] e1, input logic [63:0] e2,
                          input logic h1, input logic h2, input logic [5:0] c,
                          input bit cnb, input logic [63:0] enb);
    exp_t e;
    e.name = n; e.op1 = e1; e.op2 = e2; e.hz1 = h1; e.hz2 = h2; e.cnt = c;
    e.chk_nb = cnb; e.nb_op1 = enb;
    q.push_back(e);
  endtask

  // Monitor: compare outputs mid-cycle against every queued expectation.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if ((op1 !== e.op1) || (op2 !== e.op2) || (hz1 !== e.hz1) || (hz2 !== e.hz2) ||
          (cnt !== e.cnt) || (e.chk_nb && (nb_op1 !== e.nb_op1))) begin
        n_fail++;
        $display("FAIL %s: got op1=%h op2=%h hz=%b%b cnt=%0d nb_op1=%h; want op1=%h op2=%h hz=%b%b cnt=%0d nb_op1=%h",
                 e.name, op1, op2, hz1, hz2, cnt, nb_op1,
                 e.op1, e.op2, e.hz1, e.hz2, e.cnt, e.chk_nb ? e.nb_op1 : nb_op1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rsel1 = '0; rsel2 = '0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0;
    data_in = '0; rsv_en = 1'b0; rsv_addr = '0;

    cyc(1, 5'h00, 5'h00, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    cyc(0, 5'h13, 5'h02, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("reset_read", 64'h0, 64'h0, 0, 0, 6'd0, 1, 64'h0);

    cyc(0, 5'h13, 5'h02, 1, 5'h13, 4'h0, 64'h0001_0002_0003_BEEF, 0, 5'h00);
    exp_push("sc_wr_bypass", bc(16'hBEEF), 64'h0, 0, 0, 6'd0, 1, 64'h0);

    cyc(0, 5'h13, 5'h10, 1, 5'h10, 4'hF, bc(16'h1234), 0, 5'h00);
    exp_push("sc_read_after_wr", bc(16'hBEEF), 64'h0, 0, 0, 6'd0, 1, bc(16'hBEEF));

    cyc(0, 5'h10, 5'h13, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("sc_zero_hardwired", 64'h0, bc(16'hBEEF), 0, 0, 6'd0, 1, 64'h0);

    cyc(0, 5'h02, 5'h13, 1, 5'h02, 4'hF, v(16'h1111, 16'h2222, 16'h3333, 16'h4444), 0, 5'h00);
    exp_push("vec_wr_full", v(16'h1111, 16'h2222, 16'h3333, 16'h4444), bc(16'hBEEF),
             0, 0, 6'd0, 1, 64'h0);

    cyc(0, 5'h02, 5'h13, 1, 5'h02, 4'b0101, v(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD), 0, 5'h00);
    exp_push("vec_mask_bypass", v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), bc(16'hBEEF),
             0, 0, 6'd0, 1, v(16'h1111, 16'h2222, 16'h3333, 16'h4444));

    cyc(0, 5'h02, 5'h08, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("vec_mask_stored", v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 64'h0,
             0, 0, 6'd0, 1, v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD));

    cyc(0, 5'h05, 5'h02, 0, 5'h00, 4'h0, 64'h0, 1, 5'h05);
    exp_push("rsv_issue", 64'h0, v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 0, 0, 6'd0, 0, 64'h0);

    cyc(0, 5'h05, 5'h02, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("rsv_hazard", 64'h0, v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 1, 0, 6'd1, 0, 64'h0);

    cyc(0, 5'h05, 5'h02, 1, 5'h05, 4'hF, v(16'h5, 16'h6, 16'h7, 16'h8), 0, 5'h00);
    exp_push("wr_resolves_hazard", v(16'h5, 16'h6, 16'h7, 16'h8),
             v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 0, 0, 6'd1, 1, 64'h0);

    cyc(0, 5'h05, 5'h02, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("busy_cleared", v(16'h5, 16'h6, 16'h7, 16'h8),
             v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 0, 0, 6'd0, 0, 64'h0);

    cyc(0, 5'h05, 5'h02, 0, 5'h00, 4'h0, 64'h0, 1, 5'h05);
    exp_push("rsv_again", v(16'h5, 16'h6, 16'h7, 16'h8),
             v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 0, 0, 6'd0, 0, 64'h0);

    cyc(0, 5'h05, 5'h02, 1, 5'h05, 4'b0000, bc(16'h9999), 1, 5'h05);
    exp_push("rsv_wr_same", v(16'h5, 16'h6, 16'h7, 16'h8),
             v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 0, 0, 6'd1, 1, v(16'h5, 16'h6, 16'h7, 16'h8));

    cyc(0, 5'h05, 5'h02, 0, 5'h00, 4'h0, 64'h0, 1, 5'h10);
    exp_push("rsv_wins", v(16'h5, 16'h6, 16'h7, 16'h8),
             v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 1, 0, 6'd1, 0, 64'h0);

    cyc(0, 5'h05, 5'h10, 0, 5'h00, 4'h0, 64'h0, 1, 5'h05);
    exp_push("rsv_sc0_ignored", v(16'h5, 16'h6, 16'h7, 16'h8), 64'h0, 1, 0, 6'd1, 0, 64'h0);

    cyc(0, 5'h05, 5'h0A, 0, 5'h00, 4'h0, 64'h0, 1, 5'h0A);
    exp_push("rsv_double", v(16'h5, 16'h6, 16'h7, 16'h8), 64'h0, 1, 0, 6'd1, 0, 64'h0);

    cyc(0, 5'h05, 5'h0A, 0, 5'h00, 4'h0, 64'h0, 1, 5'h13);
    exp_push("rsv_oor_ignored", v(16'h5, 16'h6, 16'h7, 16'h8), 64'h0, 1, 0, 6'd1, 0, 64'h0);

    cyc(0, 5'h13, 5'h02, 0, 5'h00, 4'h0, 64'h0, 1, 5'h02);
    exp_push("rsv_scalar", bc(16'hBEEF), v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD),
             1, 0, 6'd2, 0, 64'h0);

    cyc(0, 5'h01, 5'h02, 1, 5'h01, 4'hF, v(16'h1, 16'h2, 16'h3, 16'h4), 0, 5'h00);
    exp_push("three_reserved", v(16'h1, 16'h2, 16'h3, 16'h4),
             v(16'h1111, 16'hBBBB, 16'h3333, 16'hDDDD), 0, 1, 6'd3, 1, 64'h0);

    // Reset together with a write and a reservation; both must be discarded.
    cyc(1, 5'h01, 5'h13, 1, 5'h01, 4'hF, bc(16'hFFFF), 1, 5'h07);

    cyc(0, 5'h01, 5'h05, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("post_reset_a", 64'h0, 64'h0, 0, 0, 6'd0, 1, 64'h0);

    cyc(0, 5'h13, 5'h02, 0, 5'h00, 4'h0, 64'h0, 0, 5'h00);
    exp_push("post_reset_b", 64'h0, 64'h0, 0, 0, 6'd0, 1, 64'h0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
